// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between the operand-issue stage,
// its upstream (decode/regfile read) and its downstream (ALU/writeback).
//   slave  : view used by alu_issue (accepts in_*, produces out_*)
//   master : view used by the environment driving the stage
// Signals:
//   in_valid/in_ready, in_insn, in_rs1_data, in_rs2_data   - instruction in
//   out_valid/out_ready, out_alu_function, out_op_a,
//   out_op_b, out_rd, out_illegal                          - issued operation
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_function;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_insn, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_alu_function, out_op_a, out_op_b,
           out_rd, out_illegal
  );

  modport master (
    output in_valid, in_insn, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_alu_function, out_op_a, out_op_b,
           out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage in front of the ALU. Decodes RV32I OP,
// OP-IMM and LUI into an ALU_* function code, forms op_a/op_b, and holds the
// result in registers that drive the ALU directly.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - alu_issue_if.slave (input and output valid/ready handshakes)
// Build option:
//   ALU_ISSUE_SKID_EN - two-entry buffer (main + skid) with a registered
//                       in_ready; otherwise a single register with a
//                       combinational in_ready.
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_SLL  5'd2
`define ALU_SLT  5'd3
`define ALU_SLTU 5'd4
`define ALU_XOR  5'd5
`define ALU_SRL  5'd6
`define ALU_SRA  5'd7
`define ALU_OR   5'd8
`define ALU_AND  5'd9
`endif

module alu_issue (
  input logic        clock,
  input logic        reset,
  alu_issue_if.slave bus
);

  typedef struct packed {
    logic [4:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{`ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0};
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_shift;
  logic       legal;
  entry_t     dec;
  entry_t     main_q;
  logic       main_valid;
  logic       accept;

  assign opcode   = bus.in_insn[6:0];
  assign funct3   = bus.in_insn[14:12];
  assign funct7   = bus.in_insn[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  function automatic logic [4:0] base_func(input logic [2:0] f3);
    case (f3)
      3'b000:  base_func = `ALU_ADD;
      3'b001:  base_func = `ALU_SLL;
      3'b010:  base_func = `ALU_SLT;
      3'b011:  base_func = `ALU_SLTU;
      3'b100:  base_func = `ALU_XOR;
      3'b101:  base_func = `ALU_SRL;
      3'b110:  base_func = `ALU_OR;
      default: base_func = `ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec.func    = `ALU_ADD;
    dec.op_a    = 32'd0;
    dec.op_b    = 32'd0;
    dec.rd      = bus.in_insn[11:7];
    legal       = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op_a = bus.in_rs1_data;
        dec.op_b = is_shift ? {27'b0, bus.in_rs2_data[4:0]} : bus.in_rs2_data;
        if (funct7 == F7_BASE) begin
          legal    = 1'b1;
          dec.func = base_func(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal    = 1'b1;
          dec.func = `ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal    = 1'b1;
          dec.func = `ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec.op_a = bus.in_rs1_data;
        dec.op_b = is_shift ? {27'b0, bus.in_insn[24:20]}
                            : {{20{bus.in_insn[31]}}, bus.in_insn[31:20]};
        dec.func = base_func(funct3);
        // funct7 is only an encoding field for the shift forms; elsewhere
        // those bits belong to the immediate.
        if (!is_shift || funct7 == F7_BASE) begin
          legal = 1'b1;
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          legal    = 1'b1;
          dec.func = `ALU_SRA;
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        dec.op_b = {bus.in_insn[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.func = `ALU_ADD;
      dec.op_a = 32'd0;
      dec.op_b = 32'd0;
    end
    dec.illegal = !legal;
  end

  assign accept = bus.in_valid && bus.in_ready;

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q;
  logic   skid_full;
  logic   main_free;

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally; the skid entry absorbs the one accept that this costs.
  assign bus.in_ready = !skid_full;
  assign main_free    = !main_valid || bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q     <= RESET_ENTRY;
      main_valid <= 1'b0;
      skid_q     <= RESET_ENTRY;
      skid_full  <= 1'b0;
    end else if (main_free) begin
      if (skid_full) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_full  <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q    <= dec;
      skid_full <= 1'b1;
    end
  end
`else
  assign bus.in_ready = !main_valid || bus.out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q     <= RESET_ENTRY;
      main_valid <= 1'b0;
    end else if (accept) begin
      main_q     <= dec;
      main_valid <= 1'b1;
    end else if (bus.out_ready) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign bus.out_valid        = main_valid;
  assign bus.out_alu_function = main_q.func;
  assign bus.out_op_a         = main_q.op_a;
  assign bus.out_op_b         = main_q.op_b;
  assign bus.out_rd           = main_q.rd;
  assign bus.out_illegal      = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
`ifndef ALU_ADD
`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_SLL  5'd2
`define ALU_SLT  5'd3
`define ALU_SLTU 5'd4
`define ALU_XOR  5'd5
`define ALU_SRL  5'd6
`define ALU_SRA  5'd7
`define ALU_OR   5'd8
`define ALU_AND  5'd9
`endif

module tb_alu_issue;
`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_issue_if bus ();
  alu_issue dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] rs1,
                                      input logic [31:0] rs2);
    exp_t       e;
    logic [4:0] tbl[8];
    logic [6:0] opc = insn[6:0];
    logic [2:0] f3  = insn[14:12];
    logic [6:0] f7  = insn[31:25];
    bit         is_op  = (opc == 7'h33);
    bit         is_imm = (opc == 7'h13);
    bit         shift  = (f3 == 3'd1) || (f3 == 3'd5);
    bit         legal  = 1'b0;
    tbl = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
    e.rd   = insn[11:7];
    e.func = `ALU_ADD;
    e.a    = 32'd0;
    e.b    = 32'd0;
    if (opc == 7'h37) begin
      legal = 1'b1;
      e.b   = insn & 32'hFFFF_F000;
    end else if (is_op || is_imm) begin
      e.func = tbl[f3];
      e.a    = rs1;
      if (shift) e.b = is_op ? rs2 % 32 : 32'(insn[24:20]);
      else       e.b = is_op ? rs2 : {{20{insn[31]}}, insn[31:20]};
      if (f7 == 7'h00) legal = 1'b1;
      else if (f7 == 7'h20 && (f3 == 3'd5 || (is_op && f3 == 3'd0))) begin
        legal  = 1'b1;
        e.func = (f3 == 3'd5) ? `ALU_SRA : `ALU_SUB;
      end else if (is_imm && !shift) legal = 1'b1;
    end
    if (!legal) begin
      e.func = `ALU_ADD;
      e.a    = 32'd0;
      e.b    = 32'd0;
    end
    e.ill = !legal;
    return e;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [31:0] r    = $urandom;
    int          kind = $urandom_range(0, 9);
    logic [6:0]  f7;
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h00;
      default: f7 = 7'($urandom);
    endcase
    if (kind <= 3)      r[6:0] = 7'b0110011;
    else if (kind <= 6) r[6:0] = 7'b0010011;
    else if (kind <= 8) r[6:0] = 7'b0110111;
    if (kind <= 6) r[31:25] = f7;
    return r;
  endfunction

  task automatic check_vs_model();
    logic exp_ready;
    exp_ready = SKID ? (sb.size() < 2) : (sb.size() == 0 || bus.out_ready);
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, sb.size() > 0);
    if (sb.size() > 0) begin
      check("func", bus.out_alu_function, sb[0].func);
      check("op_a", bus.out_op_a, sb[0].a);
      check("op_b", bus.out_op_b, sb[0].b);
      check("rd", bus.out_rd, sb[0].rd);
      check("illegal", bus.out_illegal, sb[0].ill);
    end
  endtask

  vec_t vecs[7];
  int   acc_cnt;
  bit   acc, con, acc_last;

  initial begin
    vecs[0] = '{32'h00500093, 32'd0, 32'd0, `ALU_ADD, 32'd0, 32'd5, 5'd1, 1'b0};
    vecs[1] = '{32'h402081B3, 32'd10, 32'd3, `ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b0};
    vecs[2] = '{32'h4073D2B3, 32'h8000_0000, 32'h24, `ALU_SRA, 32'h8000_0000, 32'd4, 5'd5, 1'b0};
    vecs[3] = '{32'h41F35293, 32'h1234_5678, 32'd7, `ALU_SRA, 32'h1234_5678, 32'd31, 5'd5, 1'b0};
    vecs[4] = '{32'hABCDE237, 32'h55, 32'h66, `ALU_ADD, 32'd0, 32'hABCD_E000, 5'd4, 1'b0};
    vecs[5] = '{32'h00012083, 32'h77, 32'h88, `ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b1};
    vecs[6] = '{32'h022081B3, 32'h99, 32'hAA, `ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b1};

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_insn     = 32'd0;
    bus.in_rs1_data = 32'd0;
    bus.in_rs2_data = 32'd0;
    bus.out_ready   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst func", bus.out_alu_function, `ALU_ADD);
    check("rst op_a", bus.out_op_a, 32'd0);
    check("rst op_b", bus.out_op_b, 32'd0);
    check("rst rd", bus.out_rd, 5'd0);
    check("rst illegal", bus.out_illegal, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);

    // Directed decode vectors, one at a time, held on the output one cycle.
    foreach (vecs[i]) begin
      @(negedge clock);
      bus.in_valid    = 1'b1;
      bus.in_insn     = vecs[i].insn;
      bus.in_rs1_data = vecs[i].rs1;
      bus.in_rs2_data = vecs[i].rs2;
      bus.out_ready   = 1'b0;
      @(negedge clock);
      bus.in_valid = 1'b0;
      #1;
      check($sformatf("v%0d valid", i), bus.out_valid, 1'b1);
      check($sformatf("v%0d func", i), bus.out_alu_function, vecs[i].func);
      check($sformatf("v%0d op_a", i), bus.out_op_a, vecs[i].a);
      check($sformatf("v%0d op_b", i), bus.out_op_b, vecs[i].b);
      check($sformatf("v%0d rd", i), bus.out_rd, vecs[i].rd);
      check($sformatf("v%0d illegal", i), bus.out_illegal, vecs[i].ill);
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      #1;
      check($sformatf("v%0d drained", i), bus.out_valid, 1'b0);
    end

    // Backpressure: count accepts until in_ready drops (bounded).
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.in_valid    = 1'b1;
      bus.in_insn     = 32'h00500013 | (32'(i + 10) << 7);
      bus.in_rs1_data = 32'd0;
      #1;
      if (!bus.in_ready) break;
      acc_cnt++;
    end
    check("accepts before stall", acc_cnt, SKID ? 2 : 1);
    check("stall head rd", bus.out_rd, 5'd10);

    // Reset while entries are held must drop out_valid without a clock edge.
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("pre-reset valid", bus.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("async reset valid", bus.out_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post-reset valid", bus.out_valid, 1'b0);
    check("post-reset in_ready", bus.in_ready, 1'b1);
    @(negedge clock);
    bus.in_valid    = 1'b1;
    bus.in_insn     = 32'h00500493;
    bus.in_rs1_data = 32'd0;
    bus.out_ready   = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    #1;
    check("fresh valid", bus.out_valid, 1'b1);
    check("fresh rd", bus.out_rd, 5'd9);
    @(negedge clock);
    #1;
    check("no stale entry", bus.out_valid, 1'b0);

    // Randomized traffic against the queue model.
    acc_last = 1'b1;
    acc_cnt  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!bus.in_valid || acc_last) begin
        bus.in_valid    = (c < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.in_insn     = gen_insn();
        bus.in_rs1_data = $urandom;
        bus.in_rs2_data = $urandom;
      end
      if (c < 200)       bus.out_ready = 1'b1;
      else if (c < 1600) bus.out_ready = $urandom_range(0, 1);
      else               bus.out_ready = ($urandom_range(0, 3) == 0);
      #1;
      check_vs_model();
      acc = bus.in_valid && bus.in_ready;
      con = bus.out_valid && bus.out_ready;
      if (c < 200 && acc) acc_cnt++;
      @(posedge clock);
      if (con && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(ref_decode(bus.in_insn, bus.in_rs1_data, bus.in_rs2_data));
      acc_last = acc;
    end
    check("full-rate accepts", acc_cnt, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
